alien_hit_detector: RTL and testbench

Pixel-rate collision detector between the cannon laser and the alien formation. It consumes the per-pixel `laser_gfx` and `alien_pixel` streams together with the raster position, and resolves the first laser/alien overlap in each frame to a formation row and column. At the start of vertical blanking it:

- feeds a kill request to `alien_formation`,
- raises `hit_alien` to `cannon_laser`, which replaces that module's tied-off input,
- adds row-weighted points to a BCD score.

---
 rtl/alien_hit_detector.sv | 158 +++++++++++++++
 tb/tb_alien_hit_detector.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alien_hit_detector.sv
// Laser/alien collision detector: latches the first qualified overlap per frame, commits at vblank start.
// Outputs registered, visible one cycle after (0,V_ACTIVE) is sampled; no backpressure, kill is a 1-clk pulse.
module alien_hit_detector #(
   parameter int NUM_ROWS        = 3,
   parameter int NUM_COLUMNS     = 5,
   parameter int ALIEN_SPACING_X = 64,
   parameter int ALIEN_SPACING_Y = 32,
   parameter int START_X         = 100,
   parameter int START_Y         = 50,
   parameter int V_ACTIVE        = 480
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [9:0]                            hpos,
   input  logic [9:0]                            vpos,
   input  logic                                  display_on,
   input  logic                                  laser_gfx,
   input  logic                                  alien_pixel,
   input  logic [NUM_ROWS-1:0][NUM_COLUMNS-1:0]  alive_matrix,
   output logic                                  hit_alien,
   output logic                                  kill_valid,
   output logic [$clog2(NUM_ROWS)-1:0]           kill_row,
   output logic [$clog2(NUM_COLUMNS)-1:0]        kill_col,
   output logic [15:0]                           score_bcd
);
   localparam int RW  = $clog2(NUM_ROWS);
   localparam int CW  = $clog2(NUM_COLUMNS);
   localparam int SHX = $clog2(ALIEN_SPACING_X);
   localparam int SHY = $clog2(ALIEN_SPACING_Y);

   typedef enum logic [1:0] {S_SCAN, S_LATCHED, S_BLANK_HIT, S_BLANK} state_t;

   state_t            r_state, w_state_nxt;
   logic [RW-1:0]     r_pend_row, w_pend_row_nxt;
   logic [CW-1:0]     r_pend_col, w_pend_col_nxt;
   logic              r_kill_valid, w_kill_valid_nxt;
   logic [RW-1:0]     r_kill_row, w_kill_row_nxt;
   logic [CW-1:0]     r_kill_col, w_kill_col_nxt;
   logic              r_hit_alien, w_hit_alien_nxt;
   logic [15:0]       r_score, w_score_nxt;

   logic signed [10:0] w_dx, w_dy;
   logic [9:0]         w_col_full, w_row_full;
   logic [RW-1:0]      w_row;
   logic [CW-1:0]      w_col;
   logic               w_in_grid, w_alive, w_collide, w_commit, w_top;

   // Signed differences: a pixel left of / above the grid origin has bit 10 set and is rejected.
   assign w_dx       = $signed({1'b0, hpos}) - $signed(11'(START_X));
   assign w_dy       = $signed({1'b0, vpos}) - $signed(11'(START_Y));
   assign w_col_full = w_dx[9:0] >> SHX;
   assign w_row_full = w_dy[9:0] >> SHY;
   assign w_col      = w_col_full[CW-1:0];
   assign w_row      = w_row_full[RW-1:0];
   assign w_in_grid  = !w_dx[10] && !w_dy[10] &&
                       (w_col_full < 10'(NUM_COLUMNS)) && (w_row_full < 10'(NUM_ROWS));
   assign w_alive    = w_in_grid && alive_matrix[w_row][w_col];
   assign w_collide  = display_on && laser_gfx && alien_pixel && w_alive;
   assign w_commit   = (hpos == 10'd0) && (vpos == 10'(V_ACTIVE));
   assign w_top      = (hpos == 10'd0) && (vpos == 10'd0);

   function automatic logic [15:0] row_points(input logic [RW-1:0] row);
      if (row == RW'(0))      return 16'h0030;
      else if (row == RW'(1)) return 16'h0020;
      else                    return 16'h0010;
   endfunction

   // Digit-serial BCD add; a carry out of the top digit means the sum passed 9999.
   function automatic logic [15:0] bcd_add_sat(input logic [15:0] a, input logic [15:0] b);
      logic [15:0] s;
      logic [4:0]  d;
      logic        c;
      s = 16'h0000;
      c = 1'b0;
      for (int i = 0; i < 4; i++) begin
         d = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'b0000, c};
         if (d > 5'd9) begin
            d = d + 5'd6;
            c = 1'b1;
         end else begin
            c = 1'b0;
         end
         s[i*4 +: 4] = d[3:0];
      end
      return c ? 16'h9999 : s;
   endfunction

   always_comb begin
      w_state_nxt      = r_state;
      w_pend_row_nxt   = r_pend_row;
      w_pend_col_nxt   = r_pend_col;
      w_kill_valid_nxt = 1'b0;
      w_kill_row_nxt   = r_kill_row;
      w_kill_col_nxt   = r_kill_col;
      w_hit_alien_nxt  = r_hit_alien;
      w_score_nxt      = r_score;
      case (r_state)
         S_SCAN: begin
            if (w_collide) begin
               w_pend_row_nxt = w_row;
               w_pend_col_nxt = w_col;
               w_state_nxt    = S_LATCHED;
            end else if (w_commit) begin
               w_state_nxt = S_BLANK;
            end
         end
         S_LATCHED: begin
            if (w_commit) begin
               w_kill_valid_nxt = 1'b1;
               w_kill_row_nxt   = r_pend_row;
               w_kill_col_nxt   = r_pend_col;
               w_hit_alien_nxt  = 1'b1;
               w_score_nxt      = bcd_add_sat(r_score, row_points(r_pend_row));
               w_state_nxt      = S_BLANK_HIT;
            end
         end
         S_BLANK_HIT: begin
            if (w_top) begin
               w_hit_alien_nxt = 1'b0;
               w_state_nxt     = S_SCAN;
            end
         end
         S_BLANK: begin
            if (w_top) w_state_nxt = S_SCAN;
         end
         default: w_state_nxt = S_SCAN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_SCAN;
         r_pend_row   <= '0;
         r_pend_col   <= '0;
         r_kill_valid <= 1'b0;
         r_kill_row   <= '0;
         r_kill_col   <= '0;
         r_hit_alien  <= 1'b0;
         r_score      <= 16'h0000;
      end else begin
         r_state      <= w_state_nxt;
         r_pend_row   <= w_pend_row_nxt;
         r_pend_col   <= w_pend_col_nxt;
         r_kill_valid <= w_kill_valid_nxt;
         r_kill_row   <= w_kill_row_nxt;
         r_kill_col   <= w_kill_col_nxt;
         r_hit_alien  <= w_hit_alien_nxt;
         r_score      <= w_score_nxt;
      end
   end

   assign hit_alien  = r_hit_alien;
   assign kill_valid = r_kill_valid;
   assign kill_row   = r_kill_row;
   assign kill_col   = r_kill_col;
   assign score_bcd  = r_score;

endmodule

// File: tb/tb_alien_hit_detector.sv
// Bench for alien_hit_detector: compressed rasters (only the pixels that matter plus the blanking
// landmarks) driven frame by frame, compared against an arithmetic model of the collision rules.
module tb_alien_hit_detector;
   localparam int NR = 3, NC = 5, SX = 64, SY = 32, X0 = 100, Y0 = 50, VA = 480;

   logic clk = 1'b0;
   always #20 clk = ~clk;

   logic                 reset;
   logic [9:0]           hpos, vpos;
   logic                 display_on, laser_gfx, alien_pixel;
   logic [NR-1:0][NC-1:0] alive_matrix;
   logic                 hit_alien, kill_valid;
   logic [1:0]           kill_row;
   logic [2:0]           kill_col;
   logic [15:0]          score_bcd;

   alien_hit_detector dut (
      .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
      .laser_gfx(laser_gfx), .alien_pixel(alien_pixel), .alive_matrix(alive_matrix),
      .hit_alien(hit_alien), .kill_valid(kill_valid), .kill_row(kill_row),
      .kill_col(kill_col), .score_bcd(score_bcd)
   );

   typedef struct { int x; int y; bit disp; bit laser; bit alien; } pix_t;
   pix_t evq[$];

   int n_cmp = 0, n_fail = 0;
   int model_score = 0;

   int o_kills, o_row, o_col;
   bit o_kill_bad, o_hit_early, o_hit_blank_all, o_hit_blank_any, o_hit_after, o_score_stray;

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // Geometry rules applied with plain integer arithmetic.
   function automatic bit qualifies(input pix_t p, output int r, output int c);
      int dx, dy;
      dx = p.x - X0;
      dy = p.y - Y0;
      r = 0; c = 0;
      if (!(p.disp && p.laser && p.alien)) return 0;
      if (dx < 0 || dy < 0) return 0;
      c = dx / SX;
      r = dy / SY;
      if (c >= NC || r >= NR) return 0;
      return alive_matrix[r][c];
   endfunction

   task automatic model_frame(input int rst_at, output bit hit, output int row, output int col);
      int r, c;
      hit = 0; row = 0; col = 0;
      foreach (evq[i]) begin
         if (!hit && qualifies(evq[i], r, c)) begin
            hit = 1; row = r; col = c;
         end
         if (i == rst_at) begin
            hit = 0; model_score = 0;
         end
      end
      if (hit) begin
         model_score += (row == 0) ? 30 : (row == 1) ? 20 : 10;
         if (model_score > 9999) model_score = 9999;
      end
   endtask

   task automatic add_ev(input int x, input int y, input bit d, input bit l, input bit a);
      pix_t p;
      p.x = x; p.y = y; p.disp = d; p.laser = l; p.alien = a;
      evq.push_back(p);
   endtask

   task automatic drive(input int x, input int y, input bit d, input bit l, input bit a);
      hpos = 10'(x); vpos = 10'(y); display_on = d; laser_gfx = l; alien_pixel = a;
   endtask

   // phase: 0 active, 1 first blank sample, 2 blank, 3 after (0,0), 4 reset cycle
   task automatic tick(input int phase);
      logic [15:0] prev;
      prev = score_bcd;
      @(posedge clk); #1;
      if (phase == 4) return;
      if (kill_valid === 1'b1) begin
         o_kills++; o_row = int'(kill_row); o_col = int'(kill_col);
         if (phase != 1) o_kill_bad = 1;
      end
      if (score_bcd !== prev && kill_valid !== 1'b1) o_score_stray = 1;
      if (phase == 0 && hit_alien !== 1'b0) o_hit_early = 1;
      if (phase == 1 || phase == 2) begin
         if (hit_alien === 1'b1) o_hit_blank_any = 1;
         else o_hit_blank_all = 0;
      end
      if (phase == 3 && hit_alien !== 1'b0) o_hit_after = 1;
   endtask

   task automatic run_frame(input int rst_at);
      o_kills = 0; o_row = -1; o_col = -1; o_kill_bad = 0; o_hit_early = 0;
      o_hit_blank_all = 1; o_hit_blank_any = 0; o_hit_after = 0; o_score_stray = 0;
      drive(3, 3, 1, 0, 0); tick(0);
      foreach (evq[i]) begin
         drive(evq[i].x, evq[i].y, evq[i].disp, evq[i].laser, evq[i].alien); tick(0);
         drive(620, evq[i].y, 1, 0, 0); tick(0);
         if (i == rst_at) begin
            reset = 1'b1; drive(630, evq[i].y + 1, 1, 0, 0); tick(4); reset = 1'b0;
         end
      end
      drive(639, VA - 1, 1, 0, 0); tick(0);
      drive(0, VA, 0, 0, 0); tick(1);
      for (int k = 0; k < 5; k++) begin
         drive(16 + k, 490 + k, 0, 0, 0); tick(2);
      end
      drive(0, 0, 0, 0, 0); tick(3);
      drive(1, 0, 1, 0, 0); tick(3);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(5, 5, 0, 0, 0);
      for (int k = 0; k < 4; k++) tick(4);
      reset = 1'b0;
      model_score = 0;
      tick(4);
   endtask

   task automatic test_reset();
      alive_matrix = '1;
      do_reset();
      n_cmp++; if (hit_alien !== 1'b0) begin n_fail++; $display("FAIL rst_hit: got %b want 0", hit_alien); end
      n_cmp++; if (kill_valid !== 1'b0) begin n_fail++; $display("FAIL rst_kill_valid: got %b want 0", kill_valid); end
      n_cmp++; if (kill_row !== 2'd0) begin n_fail++; $display("FAIL rst_kill_row: got %0d want 0", kill_row); end
      n_cmp++; if (kill_col !== 3'd0) begin n_fail++; $display("FAIL rst_kill_col: got %0d want 0", kill_col); end
      n_cmp++; if (score_bcd !== 16'h0000) begin n_fail++; $display("FAIL rst_score: got %h want 0000", score_bcd); end
      evq.delete();
      run_frame(-1);
      n_cmp++; if (o_kills !== 0) begin n_fail++; $display("FAIL idle_kills: got %0d want 0", o_kills); end
      n_cmp++; if (o_hit_blank_any !== 1'b0 || o_hit_after !== 1'b0) begin
         n_fail++; $display("FAIL idle_hit: got blank=%b after=%b want 0/0", o_hit_blank_any, o_hit_after); end
   endtask

   task automatic test_single_hit();
      evq.delete(); add_ev(170, 60, 1, 1, 1);
      run_frame(-1);
      n_cmp++; if (o_kills !== 1 || o_kill_bad !== 1'b0) begin
         n_fail++; $display("FAIL single_pulse: got %0d pulses (misplaced=%b) want 1 at commit", o_kills, o_kill_bad); end
      n_cmp++; if (o_row !== 0 || o_col !== 1) begin
         n_fail++; $display("FAIL single_cell: got r%0d c%0d want r0 c1", o_row, o_col); end
      n_cmp++; if (score_bcd !== 16'h0030) begin n_fail++; $display("FAIL single_score: got %h want 0030", score_bcd); end
      n_cmp++; if (o_hit_early !== 1'b0 || o_hit_blank_all !== 1'b1 || o_hit_after !== 1'b0) begin
         n_fail++; $display("FAIL single_hit_level: got early=%b blank_all=%b after=%b want 0/1/0",
                            o_hit_early, o_hit_blank_all, o_hit_after); end
      n_cmp++; if (o_score_stray !== 1'b0) begin n_fail++; $display("FAIL single_score_stray: score moved without kill"); end
      n_cmp++; if (kill_row !== 2'd0 || kill_col !== 3'd1 || kill_valid !== 1'b0) begin
         n_fail++; $display("FAIL single_hold: got v%b r%0d c%0d want v0 r0 c1", kill_valid, kill_row, kill_col); end
   endtask

   task automatic test_first_hit_wins();
      evq.delete(); add_ev(170, 60, 1, 1, 1); add_ev(300, 120, 1, 1, 1);
      run_frame(-1);
      n_cmp++; if (o_kills !== 1 || o_row !== 0 || o_col !== 1) begin
         n_fail++; $display("FAIL first_wins: got %0d kills r%0d c%0d want 1 r0 c1", o_kills, o_row, o_col); end
      n_cmp++; if (score_bcd !== 16'h0060) begin n_fail++; $display("FAIL first_wins_score: got %h want 0060", score_bcd); end
      evq.delete(); add_ev(300, 120, 1, 1, 1);
      run_frame(-1);
      n_cmp++; if (o_kills !== 1 || o_row !== 2 || o_col !== 3) begin
         n_fail++; $display("FAIL row2_cell: got %0d kills r%0d c%0d want 1 r2 c3", o_kills, o_row, o_col); end
      n_cmp++; if (score_bcd !== 16'h0070) begin n_fail++; $display("FAIL row2_score: got %h want 0070", score_bcd); end
   endtask

   task automatic test_rejections();
      for (int k = 0; k < 4; k++) begin
         alive_matrix = '1;
         evq.delete();
         case (k)
            0: begin alive_matrix[0][1] = 1'b0; add_ev(170, 60, 1, 1, 1); end
            1: add_ev(90, 60, 1, 1, 1);
            2: add_ev(430, 60, 1, 1, 1);
            default: add_ev(170, 60, 0, 1, 1);
         endcase
         run_frame(-1);
         n_cmp++; if (o_kills !== 0 || o_hit_blank_any !== 1'b0) begin
            n_fail++; $display("FAIL reject_%0d: got %0d kills hit=%b want 0/0", k, o_kills, o_hit_blank_any); end
         n_cmp++; if (score_bcd !== 16'h0070) begin n_fail++; $display("FAIL reject_score_%0d: got %h want 0070", k, score_bcd); end
      end
      alive_matrix = '1;
   endtask

   task automatic test_saturation();
      int bad;
      do_reset();
      evq.delete(); add_ev(170, 60, 1, 1, 1);
      bad = 0;
      for (int f = 0; f < 333; f++) begin
         run_frame(-1);
         if (o_kills != 1) bad++;
      end
      n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL preload_kills: got %0d bad frames want 0", bad); end
      n_cmp++; if (score_bcd !== 16'h9990) begin n_fail++; $display("FAIL preload_score: got %h want 9990", score_bcd); end
      for (int f = 0; f < 3; f++) begin
         run_frame(-1);
         n_cmp++; if (o_kills !== 1) begin n_fail++; $display("FAIL sat_pulse_%0d: got %0d want 1", f, o_kills); end
         n_cmp++; if (score_bcd !== 16'h9999) begin n_fail++; $display("FAIL sat_score_%0d: got %h want 9999", f, score_bcd); end
      end
   endtask

   task automatic test_mid_reset();
      evq.delete(); add_ev(170, 60, 1, 1, 1);
      run_frame(0);
      n_cmp++; if (o_kills !== 0 || o_hit_blank_any !== 1'b0 || o_hit_after !== 1'b0) begin
         n_fail++; $display("FAIL midrst_kill: got %0d kills hit=%b want 0/0", o_kills, o_hit_blank_any); end
      n_cmp++; if (score_bcd !== 16'h0000) begin n_fail++; $display("FAIL midrst_score: got %h want 0000", score_bcd); end
   endtask

   task automatic test_random();
      bit eh; int er, ec, nev;
      do_reset();
      for (int f = 0; f < 60; f++) begin
         alive_matrix = 15'($urandom) | 15'($urandom);
         evq.delete();
         nev = $urandom_range(0, 3);
         for (int e = 0; e < nev; e++)
            add_ev($urandom_range(60, 480), $urandom_range(30, 170),
                   $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
         model_frame(-1, eh, er, ec);
         run_frame(-1);
         n_cmp++; if (o_kills !== int'(eh) || o_hit_blank_any !== eh) begin
            n_fail++; $display("FAIL rand_kill_f%0d: got %0d kills hit=%b want %0d", f, o_kills, o_hit_blank_any, eh); end
         if (eh) begin
            n_cmp++; if (o_row !== er || o_col !== ec) begin
               n_fail++; $display("FAIL rand_cell_f%0d: got r%0d c%0d want r%0d c%0d", f, o_row, o_col, er, ec); end
         end
         n_cmp++; if (score_bcd !== to_bcd(model_score)) begin
            n_fail++; $display("FAIL rand_score_f%0d: got %h want %h", f, score_bcd, to_bcd(model_score)); end
      end
   endtask

   initial begin
      reset = 1'b0;
      alive_matrix = '1;
      drive(0, 0, 0, 0, 0);
      test_reset();
      test_single_hit();
      test_first_hit_wins();
      test_rejections();
      test_saturation();
      test_mid_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
